// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU sequencer. It feeds a single alu1 slice one bit
// per cycle, LSB first, and carries between bits through a register.
// alu_serial: latch operands on an accepted start, run WIDTH slice cycles,
// then pulse done with the result word and its flags.

// alu1: 1-bit ALU slice. Arithmetic when control[2]=0 (control[0]=1 inverts B
// for subtract). Logic when control[2]=1: and / or / nor / xor.
module alu1 (
  output logic       out,
  output logic       carryout,
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control
);

  logic b_eff;

  // Full adder for arithmetic codes, bitwise function for logic codes
  always_comb begin
    b_eff    = control[0] ? ~B : B;
    out      = 1'b0;
    carryout = 1'b0;
    if (!control[2]) begin
      out      = A ^ b_eff ^ carryin;
      carryout = (A & b_eff) | (A & carryin) | (b_eff & carryin);
    end else begin
      unique case (control[1:0])
        2'b00:   out = A & B;
        2'b01:   out = A | B;
        2'b10:   out = ~(A | B);
        default: out = A ^ B;
      endcase
    end
  end

endmodule

module alu_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;
  logic             carry_q;
  logic [WIDTH-1:0] out_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic             accept;
  logic             last_bit;
  logic             s_cin;
  logic             s_out;
  logic             s_cout;
  logic [WIDTH-1:0] out_d;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;

  alu1 u_slice (
    .out      (s_out),
    .carryout (s_cout),
    .A        (a_q[cnt_q]),
    .B        (b_q[cnt_q]),
    .carryin  (s_cin),
    .control  (ctrl_q)
  );

  // Slice carry-in, next result word, and the flags captured with the final bit
  always_comb begin
    accept   = start && (state_q != RUN);
    last_bit = (cnt_q == CW'(WIDTH - 1));
    if (cnt_q == '0) s_cin = ~ctrl_q[2] & ctrl_q[0];
    else             s_cin = carry_q;
    out_d        = out_q;
    out_d[cnt_q] = s_out;
    // At the MSB, s_cin is the carry into it and s_cout the carry out of it
    ovf_d  = ~ctrl_q[2] & (s_cin ^ s_cout);
    zero_d = (out_d == '0);
    neg_d  = out_d[WIDTH-1];
  end

  // Sequencer: IDLE/DONE accept a start, RUN walks the bits LSB first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            ctrl_q  <= control;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            out_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          out_q   <= out_d;
          carry_q <= s_cout;
          if (last_bit) begin
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (WIDTH=32): table of single operations plus
// hand-written sequences for busy-start, mid-run reset and back-to-back runs.
module tb_alu_serial;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   control;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         overflow;
  logic         zero;
  logic         negative;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .control  (control),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   ctrl;
    logic [W-1:0] exp_out;
    logic         exp_ovf;
    logic         exp_zero;
    logic         exp_neg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One start pulse, then wait (bounded) for done; checks latency and results
  task automatic run_op(input vec_t v, input string tag);
    int unsigned cyc;
    int unsigned busy_cnt;
    logic        seen;
    @(negedge clk);
    A = v.a; B = v.b; control = v.ctrl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    cyc = 0;
    for (int unsigned i = 1; i <= 100; i++) begin
      if (done) begin
        seen = 1'b1;
        cyc = i;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk({tag, " done_seen"}, W'(seen), W'(1));
    chk({tag, " done_cycle"}, W'(cyc), W'(33));
    chk({tag, " busy_cycles"}, W'(busy_cnt), W'(32));
    chk({tag, " out"}, out, v.exp_out);
    chk({tag, " overflow"}, W'(overflow), W'(v.exp_ovf));
    chk({tag, " zero"}, W'(zero), W'(v.exp_zero));
    chk({tag, " negative"}, W'(negative), W'(v.exp_neg));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, W'(done), W'(0));
    chk({tag, " out_held"}, out, v.exp_out);
  endtask

  initial begin
    int unsigned dcount;
    int unsigned dcyc;
    int unsigned d1;
    int unsigned d2;
    logic [W-1:0] dout;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 3'd2, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd2, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0005, 3'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 32'h000F_000F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0002, 32'h0000_0003, 3'd0, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0003, 32'h0000_0005, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{32'h8000_0000, 32'h0000_0001, 3'd3, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; control = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst out", out, '0);
    chk("rst overflow", W'(overflow), W'(0));
    chk("rst zero", W'(zero), W'(1));
    chk("rst negative", W'(negative), W'(0));

    // Reset and start together: reset wins
    start = 1'b1; A = 32'h1; B = 32'h1; control = 3'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_vs_start busy", W'(busy), W'(0));
    @(negedge clk);
    chk("rst_vs_start busy2", W'(busy), W'(0));

    for (int unsigned i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start pulse and operand changes during RUN are ignored
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h1111_1111; control = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0; dcyc = 0; dout = '0;
    for (int unsigned i = 1; i <= 80; i++) begin
      if (i == 5) begin
        start = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; control = 3'd7;
      end
      if (i == 6) start = 1'b0;
      if (done) begin
        dcount++;
        if (dcyc == 0) begin dcyc = i; dout = out; end
      end
      @(negedge clk);
    end
    chk("busy_start done_count", W'(dcount), W'(1));
    chk("busy_start done_cycle", W'(dcyc), W'(33));
    chk("busy_start out", dout, 32'h2345_6789);

    // Reset in the middle of a run discards the operation
    A = 32'hFFFF_FFFF; B = 32'h0; control = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst busy_before", W'(busy), W'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", W'(busy), W'(0));
    chk("midrst done", W'(done), W'(0));
    chk("midrst out", out, '0);
    chk("midrst zero", W'(zero), W'(1));
    chk("midrst overflow", W'(overflow), W'(0));
    dcount = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    chk("midrst no_activity", W'(dcount), W'(0));
    run_op(vecs[0], "after_rst");

    // Back-to-back: start held high across two operations
    A = 32'h1; B = 32'h1; control = 3'd2; start = 1'b1;
    @(negedge clk);
    d1 = 0; d2 = 0;
    for (int unsigned i = 1; i <= 120; i++) begin
      if (done) begin
        if (d1 == 0) begin
          d1 = i;
          chk("b2b out1", out, 32'h0000_0002);
          chk("b2b neg1", W'(negative), W'(0));
          A = 32'h0; B = 32'h1; control = 3'd3;
        end else begin
          d2 = i;
          chk("b2b out2", out, 32'hFFFF_FFFF);
          chk("b2b neg2", W'(negative), W'(1));
          chk("b2b ovf2", W'(overflow), W'(0));
          start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    chk("b2b first_done", W'(d1), W'(33));
    chk("b2b spacing", W'(d2 - d1), W'(33));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
